// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch-stage state, PC step, reset/NOP defaults.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INCR              = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT    = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PERF_MAX             = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

  // One fetched instruction together with its fall-through address.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } if_entry_t;

  // Saturating increment for event counters.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == PERF_MAX) ? v : v + XLEN'(1);
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer holding a word that arrived while ID was stalled.
module if_hold_buf
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_i,
  input  logic      release_i,
  input  logic      invalidate_i,
  input  if_entry_t data_i,
  output logic      valid_o,
  output if_entry_t data_o
);

  logic      valid_q;
  if_entry_t data_q;

  // Invalidate wins over load; release empties the entry once ID takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (invalidate_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (release_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives imem, fills IF/ID, and selects the next PC.
// Optional event counters are enabled by defining IF_STAGE_PERF_EN.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc4
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetches,
  output logic [XLEN-1:0] perf_stall_cycles
`endif
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] pc_plus4;
  if_entry_t       fetch_entry;

  logic            ifid_load_new;
  logic            ifid_load_buf;
  logic            ifid_flush;
  logic            buf_load;
  logic            buf_release;
  logic            buf_inval;
  logic            buf_valid;
  if_entry_t       buf_data;

  logic            ifid_valid_q;
  logic [XLEN-1:0] ifid_instr_q;
  logic [XLEN-1:0] ifid_pc4_q;

  assign pc_plus4          = pc + PC_INCR;
  assign fetch_entry.instr = imem_rdata;
  assign fetch_entry.pc4   = pc_plus4;

  // State and captured request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next state: an un-acked request must still be drained after a redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (!imem_ack) state_d = DISCARD;
        end else if (imem_ack && stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) state_d = FETCH;
      end
      DISCARD: begin
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory request, next-PC choice, and IF/ID / buffer control strobes.
  always_comb begin
    pc_next       = pc;
    imem_req      = 1'b0;
    imem_addr     = '0;
    req_addr_d    = req_addr_q;
    ifid_load_new = 1'b0;
    ifid_load_buf = 1'b0;
    ifid_flush    = 1'b0;
    buf_load      = 1'b0;
    buf_release   = 1'b0;
    buf_inval     = 1'b0;
    if (reset) begin
      pc_next    = RESET_VECTOR;
      req_addr_d = '0;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req   = 1'b1;
          imem_addr  = pc;
          req_addr_d = pc;
          if (redirect) begin
            pc_next    = redirect_target;
            ifid_flush = 1'b1;
            buf_inval  = 1'b1;
          end else if (imem_ack) begin
            pc_next = pc_plus4;
            if (stall) buf_load      = 1'b1;
            else       ifid_load_new = 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_next    = redirect_target;
            ifid_flush = 1'b1;
            buf_inval  = 1'b1;
          end else if (!stall) begin
            ifid_load_buf = 1'b1;
            buf_release   = 1'b1;
          end
        end
        DISCARD: begin
          imem_req  = 1'b1;
          imem_addr = req_addr_q;
          if (redirect) begin
            pc_next    = redirect_target;
            ifid_flush = 1'b1;
            buf_inval  = 1'b1;
          end
        end
        default: begin
          pc_next = pc;
        end
      endcase
    end
  end

  if_hold_buf u_hold_buf (
    .clk          (clk),
    .reset        (reset),
    .load_i       (buf_load),
    .release_i    (buf_release),
    .invalidate_i (buf_inval),
    .data_i       (fetch_entry),
    .valid_o      (buf_valid),
    .data_o       (buf_data)
  );

  // IF/ID register: flush > new fetch > buffered word > bubble when ID consumes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
    end else if (ifid_flush) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
    end else if (ifid_load_new) begin
      ifid_valid_q <= 1'b1;
      ifid_instr_q <= fetch_entry.instr;
      ifid_pc4_q   <= fetch_entry.pc4;
    end else if (ifid_load_buf) begin
      ifid_valid_q <= buf_valid;
      ifid_instr_q <= buf_data.instr;
      ifid_pc4_q   <= buf_data.pc4;
    end else if (!stall) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

`ifdef IF_STAGE_PERF_EN
  logic [XLEN-1:0] perf_fetches_q;
  logic [XLEN-1:0] perf_stall_cycles_q;
  logic            fetch_loaded;

  assign fetch_loaded = ifid_load_new || (ifid_load_buf && buf_valid);

  // Saturating counters of delivered instructions and stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetches_q      <= '0;
      perf_stall_cycles_q <= '0;
    end else begin
      if (fetch_loaded) perf_fetches_q <= sat_inc(perf_fetches_q);
      if (stall || (state_q == HOLD)) perf_stall_cycles_q <= sat_inc(perf_stall_cycles_q);
    end
  end

  assign perf_fetches      = perf_fetches_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_if_stage;
  import mips_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_stall_cycles;
`endif

  if_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetches      (perf_fetches),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Values seen on the combinational outputs during the last driven cycle.
  logic        g_req;
  logic [31:0] g_addr;
  logic [31:0] g_pcn;

  // Reference model: a possibly abandoned request still owed an ack, words
  // waiting for a stalled ID, and the IF/ID contents.
  logic        m_orph;
  logic [31:0] m_oaddr;
  if_entry_t   m_held[$];
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [31:0] m_pf;
  logic [31:0] m_ps;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] tgt;
    logic [31:0] pcv;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pcn;
    logic        e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, answer as memory, check against the model.
  task automatic drive(input logic rst, input logic st, input logic rd,
                       input logic [31:0] tgt, input logic [31:0] pcv, input logic ack_en);
    logic        e_req;
    logic        ack;
    logic [31:0] e_addr;
    logic [31:0] e_pcn;
    logic [31:0] rdata;
    logic        fetched;
    if_entry_t   w;
    if_entry_t   h;
    reset           = rst;
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    pc              = pcv;
    e_req  = !rst && (m_held.size() == 0);
    e_addr = e_req ? (m_orph ? m_oaddr : pcv) : 32'h0;
    ack    = ack_en && e_req;
    rdata  = ack ? (e_addr ^ KEY) : $urandom();
    imem_ack   = ack;
    imem_rdata = rdata;
    fetched = e_req && ack && !m_orph;
    e_pcn  = rst ? RV : (rd ? tgt : (fetched ? pcv + 32'd4 : pcv));
    #1;
    g_req  = imem_req;
    g_addr = imem_addr;
    g_pcn  = pc_next;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, e_addr);
    chk("pc_next", pc_next, e_pcn);
    @(posedge clk);
    #1;
    w.instr = rdata;
    w.pc4   = pcv + 32'd4;
    if (rst) begin
      m_orph = 1'b0;
      m_held.delete();
      m_v = 1'b0; m_instr = NOP; m_pc4 = 32'h0;
      m_pf = 32'h0; m_ps = 32'h0;
    end else begin
      if ((st || m_held.size() != 0) && m_ps != 32'hFFFF_FFFF) m_ps++;
      if (rd) begin
        m_v = 1'b0; m_instr = NOP;
        m_held.delete();
        m_orph  = e_req && !ack;
        m_oaddr = e_addr;
      end else begin
        if (m_orph && ack) m_orph = 1'b0;
        if (st) begin
          if (fetched) m_held.push_back(w);
        end else if (m_held.size() != 0) begin
          h = m_held.pop_front();
          m_v = 1'b1; m_instr = h.instr; m_pc4 = h.pc4;
          if (m_pf != 32'hFFFF_FFFF) m_pf++;
        end else if (fetched) begin
          m_v = 1'b1; m_instr = w.instr; m_pc4 = w.pc4;
          if (m_pf != 32'hFFFF_FFFF) m_pf++;
        end else begin
          m_v = 1'b0; m_instr = NOP;
        end
      end
    end
    chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
`ifdef IF_STAGE_PERF_EN
    chk("perf_fetches", perf_fetches, m_pf);
    chk("perf_stall_cycles", perf_stall_cycles, m_ps);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcv;
    logic [31:0] tgt;
    logic [31:0] exp_instr;
    logic        st, rd, rst, ak;

    // rst st rd tgt pc ack | req addr pc_next | valid pc4
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,  32'h10,1'b0, 1'b1,32'h10,32'h10,  1'b0,32'h0};
    tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,  32'h10,1'b0, 1'b1,32'h10,32'h10,  1'b0,32'h0};
    tbl[2]  = '{1'b0,1'b0,1'b0,32'h0,  32'h10,1'b0, 1'b1,32'h10,32'h10,  1'b0,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,  32'h10,1'b1, 1'b1,32'h10,32'h14,  1'b1,32'h14};
    tbl[4]  = '{1'b0,1'b1,1'b0,32'h0,  32'h20,1'b1, 1'b1,32'h20,32'h24,  1'b1,32'h14};
    tbl[5]  = '{1'b0,1'b1,1'b0,32'h0,  32'h24,1'b1, 1'b0,32'h0, 32'h24,  1'b1,32'h14};
    tbl[6]  = '{1'b0,1'b0,1'b0,32'h0,  32'h24,1'b1, 1'b0,32'h0, 32'h24,  1'b1,32'h24};
    tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,  32'h24,1'b1, 1'b1,32'h24,32'h28,  1'b1,32'h28};
    tbl[8]  = '{1'b0,1'b0,1'b1,32'h400,32'h30,1'b0, 1'b1,32'h30,32'h400, 1'b0,32'h28};
    tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,  32'h400,1'b0,1'b1,32'h30,32'h400, 1'b0,32'h28};
    tbl[10] = '{1'b0,1'b0,1'b0,32'h0,  32'h400,1'b1,1'b1,32'h30,32'h400, 1'b0,32'h28};
    tbl[11] = '{1'b0,1'b0,1'b0,32'h0,  32'h400,1'b1,1'b1,32'h400,32'h404,1'b1,32'h404};
    tbl[12] = '{1'b0,1'b0,1'b0,32'h0,  32'hFFFF_FFFC,1'b1,1'b1,32'hFFFF_FFFC,32'h0,1'b1,32'h0};
    tbl[13] = '{1'b0,1'b0,1'b0,32'h0,  32'h50,1'b1, 1'b1,32'h50,32'h54,  1'b1,32'h54};
    tbl[14] = '{1'b0,1'b0,1'b0,32'h0,  32'h54,1'b0, 1'b1,32'h54,32'h54,  1'b0,32'h54};
    tbl[15] = '{1'b1,1'b0,1'b0,32'h0,  32'h54,1'b0, 1'b0,32'h0, 32'h0,   1'b0,32'h0};
    tbl[16] = '{1'b0,1'b0,1'b0,32'h0,  32'h0, 1'b1, 1'b1,32'h0, 32'h4,   1'b1,32'h4};
    tbl[17] = '{1'b0,1'b1,1'b0,32'h0,  32'h4, 1'b1, 1'b1,32'h4, 32'h8,   1'b1,32'h4};
    tbl[18] = '{1'b0,1'b1,1'b1,32'h100,32'h8, 1'b1, 1'b0,32'h0, 32'h100, 1'b0,32'h4};
    tbl[19] = '{1'b0,1'b0,1'b0,32'h0,  32'h100,1'b1,1'b1,32'h100,32'h104,1'b1,32'h104};

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    m_orph = 1'b0; m_oaddr = 32'h0; m_v = 1'b0; m_instr = NOP; m_pc4 = 32'h0;
    m_pf = 32'h0; m_ps = 32'h0;
    @(posedge clk);
    #1;

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset_imem_req", 32'(g_req), 32'h0);
    chk("reset_imem_addr", g_addr, 32'h0);
    chk("reset_pc_next", g_pcn, RV);
    chk("reset_ifid_valid", 32'(ifid_valid), 32'h0);
    chk("reset_ifid_instr", ifid_instr, NOP);
    chk("reset_ifid_pc4", ifid_pc4, 32'h0);

    // Directed table: wait states, stall on ack, redirect, wrap, reset mid-request
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].tgt, tbl[i].pcv, tbl[i].ack);
      exp_instr = tbl[i].e_valid ? ((tbl[i].e_pc4 - 32'd4) ^ KEY) : NOP;
      chk($sformatf("tbl%0d_req", i), 32'(g_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i), g_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_pc_next", i), g_pcn, tbl[i].e_pcn);
      chk($sformatf("tbl%0d_valid", i), 32'(ifid_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_pc4", i), ifid_pc4, tbl[i].e_pc4);
      chk($sformatf("tbl%0d_instr", i), ifid_instr, exp_instr);
    end

    // Streaming: one instruction per cycle with pc following pc_next
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    pcv = g_pcn;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, pcv, 1'b1);
      chk("stream_pc_next", g_pcn, pcv + 32'd4);
      chk("stream_valid", 32'(ifid_valid), 32'h1);
      chk("stream_pc4", ifid_pc4, 32'(4 * k));
      chk("stream_instr", ifid_instr, 32'(4 * (k - 1)) ^ KEY);
      pcv = g_pcn;
    end

`ifdef IF_STAGE_PERF_EN
    // Counters: five delivered fetches, then three stalled cycles
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    pcv = g_pcn;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, pcv, 1'b1);
      pcv = g_pcn;
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, pcv, 1'b0);
      pcv = g_pcn;
    end
    chk("perf_fetches_5", perf_fetches, 32'd5);
    chk("perf_stall_cycles_3", perf_stall_cycles, 32'd3);
`endif

    // Randomized traffic against the model
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    pcv = g_pcn;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      ak  = ($urandom_range(0, 1) == 1);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      drive(rst, st, rd, tgt, pcv, ak);
      pcv = g_pcn;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline, sitting directly downstream of the `pc` register. It consumes the current PC, issues a variable-latency request to instruction memory and loads the returned word into the IF/ID pipeline register. It computes the next-PC value that feeds back into `pc`'s write input. Because `pc` has no enable, stalls, redirects and waits are realised by choosing that next-PC value.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: next-PC value driven while `reset` is high; matches `pc` reset value.
- `NOP_INSTR`, default 32'h0000_0000: IF/ID instruction value when the register is empty or flushed.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `pc` input 32: current PC, from the PC register output.
- `pc_next` output 32: next PC, to the PC register write input.
- `imem_req` output 1: instruction memory request.
- `imem_addr` output 32: request address; held stable while `imem_req` is high and no ack has arrived.
- `imem_ack` input 1: read data valid this cycle.
- `imem_rdata` input 32: instruction word, valid when `imem_ack` is high.
- `stall` input 1: ID stage not accepting; hold IF/ID.
- `redirect` input 1: taken branch or jump resolved downstream; flush.
- `redirect_target` input 32: new PC when `redirect` is high.
- `ifid_valid` output 1: IF/ID holds a real instruction.
- `ifid_instr` output 32: fetched instruction.
- `ifid_pc4` output 32: fetch address + 4.

## Operation
- **FSM states:** FETCH, HOLD, DISCARD. Reset state is FETCH.
- **FETCH**
  - Drives `imem_req`=1 and `imem_addr`=`pc`; latches `pc` into `req_addr`.
  - No ack: `pc_next`=`pc`.
  - Ack with `stall`=0: load IF/ID with `ifid_valid`=1, `ifid_instr`=`imem_rdata`, `ifid_pc4`=`pc`+4; `pc_next`=`pc`+4.
  - Ack with `stall`=1: capture `imem_rdata` and `pc`+4 in the hold buffer; `pc_next`=`pc`+4; go to HOLD.
- **HOLD**
  - Drives `imem_req`=0; `pc_next`=`pc`.
  - When `stall`=0: transfer the buffer into IF/ID and go to FETCH.
- **DISCARD**
  - Drives `imem_req`=1 and `imem_addr`=`req_addr`; `pc_next`=`pc`.
  - On ack: drop the data and go to FETCH.
- **Redirect** has top priority in every state:
  - `pc_next`=`redirect_target`; `ifid_valid`←0 and `ifid_instr`←`NOP_INSTR`; hold buffer invalidated.
  - From FETCH without ack: go to DISCARD, because the outstanding request must complete.
  - From FETCH with a same-cycle ack: the data is dropped; stay in FETCH.
  - From HOLD or DISCARD-with-ack: go to FETCH. DISCARD without ack stays in DISCARD.
- **IF/ID register:** holds its value while `stall`=1 and no redirect is asserted.
- **Arithmetic:** 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0. Low two PC bits pass through unchecked.

## Timing
- **Reset:** `pc_next`=`RESET_VECTOR`, `imem_req`=0, `imem_addr`=0, `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`, `ifid_pc4`=0, state FETCH, hold buffer empty. `imem_req` rises the first cycle after reset deasserts.
- **Latency:** ack in cycle N → `ifid_valid`/`ifid_instr` visible in N+1. `pc` advances at the N→N+1 edge.
- **Throughput:** one instruction per cycle when memory acks in the same cycle as the request and `stall`=0.
- **Request hold:** `imem_req` and `imem_addr` remain constant from request until ack, including across a redirect.
- **Reset mid-request:** any outstanding request is abandoned. Memory must tolerate `imem_req` dropping without an ack.
- **Registered versus combinational outputs:** `pc_next`, `imem_req` and `imem_addr` are combinational from state and inputs; all `ifid_*` outputs are registered.

## Configuration
- **`IF_STAGE_PERF_EN` defined:** adds two outputs, both cleared by `reset` and saturating at 32'hFFFF_FFFF.
  - `perf_fetches` (32): increments on each IF/ID load with `ifid_valid`←1.
  - `perf_stall_cycles` (32): increments each cycle `stall`=1 or the state is HOLD.
- **Undefined:** neither port nor counter exists; all other behaviour is identical.

## Structure
- **Shared package `mips_pkg`:**
  - `if_state_t` enum (FETCH, HOLD, DISCARD).
  - `PC_INCR`=32'd4.
  - `NOP_INSTR` default.
  - `RESET_VECTOR` default.
- **Sub-module `if_hold_buf`:** one-entry buffer carrying the instruction and pc4, with load, release and invalidate controls; instantiated once.

## Test plan
- **Streaming:** reset, `imem_ack` tied to `imem_req`, `imem_rdata`=`imem_addr`^32'hA5A5_A5A5 → `ifid_pc4` reads 4, 8, 12… on consecutive cycles with `ifid_valid`=1, and `pc_next`=`pc`+4.
- **Wait states:** ack delayed 3 cycles at `pc`=0x10 → `imem_addr`=0x10 constant, `pc_next`=0x10, then `ifid_pc4`=0x14 one cycle after the ack.
- **Stall on ack:** ack at `pc`=0x20 with `stall`=1 for 2 cycles → HOLD with `imem_req`=0; on release, `ifid_instr` equals the captured word and the next fetch address is 0x24.
- **Redirect during outstanding request:** `redirect`=1, `redirect_target`=0x400 while a request at 0x30 awaits ack → `imem_addr` stays 0x30 until ack, the data is dropped, `ifid_valid`=0, and the next request goes to 0x400.
- **Boundary:** `pc`=32'hFFFF_FFFC with ack → `ifid_pc4`=0 and `pc_next`=0; `reset` asserted mid-request → all outputs return to their reset values the next cycle.
- **Perf (macro defined):** 5 fetches plus 3 stall cycles → `perf_fetches`=5, `perf_stall_cycles`=3.
